nibble_serial_adder_ctrl: RTL and testbench
===========================================

Name: nibble_serial_adder_ctrl

Overview:
Sequencer that adds two wide operands by time-multiplexing one 4-bit ripple adder, one nibble per clock, least-significant nibble first. The carry is held in a register between nibbles. The block sits between a requester (a start/done handshake) and the shared 4-bit adder datapath. It trades latency (NIBBLES cycles) for area.

Parameters:
NIBBLES, 4, number of 4-bit slices per operand; operand width W = 4*NIBBLES; legal range 1..16

Ports:
clk  input  1  system clock; all state changes on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request; sampled only when idle
a  input  W  operand A; captured on the accepted start edge
b  input  W  operand B; captured on the accepted start edge
cin  input  1  carry-in to nibble 0; captured with a/b
sum  output  W  registered result; held stable until the next completion
cout  output  1  registered carry-out of the top nibble
busy  output  1  high while an addition is in progress
done  output  1  one-cycle pulse: sum/cout just updated

Behaviour:
- Reset: on a clock edge with reset=1, the FSM goes to IDLE. sum=0, cout=0, busy=0, done=0, nibble counter=0, carry reg=0, operand shift regs=0. Reset overrides start and any in-flight run.
- FSM states:
  - IDLE: start=1 at edge E0 latches a, b, cin. Go to RUN, cnt=0, busy=1. Otherwise stay.
  - RUN: at each edge Ek (k=1..NIBBLES):
    - The adder computes opA[3:0] + opB[3:0] + carry.
    - The nibble result shifts into the top of the internal result shift reg.
    - carry <= adder carry-out; opA/opB shift right by 4; cnt increments.
    - At E_NIBBLES the final nibble is taken. sum <= assembled result, cout <= final carry, done=1, busy=0, go to IDLE.
- Latency: done is high in the cycle following edge E_NIBBLES, i.e. exactly NIBBLES cycles after the accepted start edge. busy is high for exactly NIBBLES cycles.
- done is high for exactly one cycle. sum/cout change only on the completion edge (and reset), never during RUN.
- Arithmetic: unsigned modulo 2^W; {cout,sum} = a + b + cin exactly.
- start while busy=1: ignored with no effect. It is not queued, and operands are not re-sampled.
- start high in the done cycle: the FSM is in IDLE, so the start is accepted (back-to-back). The new run begins, and sum/cout hold the previous result until the new completion.
- start held high continuously: a new run starts each time the FSM is IDLE. This gives back-to-back operation with one done per NIBBLES cycles.
- Operand inputs are don't-care except on the accepted start edge.
- NIBBLES=1: a single RUN cycle; done one cycle after start.
- Counter width: clog2(NIBBLES)+1; no wrap during a run.

Decomposition:
- Shared package (adder_ctrl_pkg):
  - NIBBLE_W=4
  - state encoding (ST_IDLE=0, ST_RUN=1)
  - a function for counter width from NIBBLES
- One natural sub-module, nibble_adder_cin: a 4-bit ripple adder with external carry-in, built from the existing full_adder cell.
  - Ports: x[3:0], y[3:0], ci, s[3:0], co.
  - The existing 4-bit adder ties carry-in to 0 and cannot chain across cycles, hence the sub-module.
- The controller holds the FSM, counter, operand/result shift regs, and the carry reg.

Test Plan:
1. NIBBLES=4, a=16'h1234, b=16'h1111, cin=0, start one cycle → busy high 4 cycles, then done pulse with sum=16'h2345, cout=0.
2. a=16'hFFFF, b=16'h0001, cin=0 → sum=16'h0000, cout=1 (carry chains through all 4 cycles); then a=16'h8000, b=16'h8000 → sum=16'h0000, cout=1.
3. a=16'h0000, b=16'hFFFF, cin=1 → sum=16'h0000, cout=1. Then a=16'h00F0, b=16'h0010, cin=0 → sum=16'h0100, cout=0.
4. Start with a=16'h0005, b=16'h0003. At cycle 2 of RUN, raise start with a=16'hAAAA, b=16'h5555 → ignored; done shows sum=16'h0008, and no second done follows.
5. Reset asserted during RUN cycle 2 → next cycle busy=0, done=0, sum=0, cout=0. A later start of 16'h0001+16'h0001 gives sum=16'h0002 after 4 cycles.
6. Back-to-back: start re-asserted in the done cycle → second result 4 cycles later, and sum holds the first result meanwhile. NIBBLES=1 instance with a=4'hF, b=4'h1 → done one cycle after start, sum=4'h0, cout=1.

Source files
------------

// File: rtl/adder_ctrl_pkg.sv
// Shared definitions for the nibble-serial adder sequencer: slice width,
// FSM state encoding and counter sizing.
package adder_ctrl_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // One extra bit keeps the count from wrapping even at the top nibble index.
  function automatic int cntWidth(input int nibbles);
    return $clog2(nibbles) + 1;
  endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell, the building block of the nibble ripple adder.
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic ci_i,
  output logic s_o,
  output logic co_o
);

  assign s_o  = a_i ^ b_i ^ ci_i;
  assign co_o = (a_i & b_i) | (ci_i & (a_i ^ b_i));

endmodule

// File: rtl/nibble_adder_cin.sv
// 4-bit ripple adder with an external carry-in so the carry can be chained
// across clock cycles by the serial controller.
module nibble_adder_cin
  import adder_ctrl_pkg::*;
(
  input  logic [NIBBLE_W-1:0] x,
  input  logic [NIBBLE_W-1:0] y,
  input  logic                ci,
  output logic [NIBBLE_W-1:0] s,
  output logic                co
);

  logic [NIBBLE_W:0] carry;

  assign carry[0] = ci;
  assign co       = carry[NIBBLE_W];

  for (genvar i = 0; i < NIBBLE_W; i++) begin : g_bit
    full_adder u_fa (
      .a_i  (x[i]),
      .b_i  (y[i]),
      .ci_i (carry[i]),
      .s_o  (s[i]),
      .co_o (carry[i+1])
    );
  end

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Wide adder built from one shared 4-bit slice, one nibble per clock,
// least-significant nibble first, with a start/done handshake.
module nibble_serial_adder_ctrl
  import adder_ctrl_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [NIBBLE_W*NIBBLES-1:0] a,
  input  logic [NIBBLE_W*NIBBLES-1:0] b,
  input  logic                       cin,
  output logic [NIBBLE_W*NIBBLES-1:0] sum,
  output logic                       cout,
  output logic                       busy,
  output logic                       done
);

  localparam int W  = NIBBLE_W * NIBBLES;
  localparam int CW = cntWidth(NIBBLES);

  state_t                state_q;
  logic [CW-1:0]         cnt_q;
  logic [W-1:0]          opA_q;
  logic [W-1:0]          opB_q;
  logic                  carry_q;
  logic [W-1:0]          res_q;
  logic [W-1:0]          res_d;
  logic [W-1:0]          sum_q;
  logic                  cout_q;
  logic                  busy_q;
  logic                  done_q;

  logic [NIBBLE_W-1:0]   nibSum;
  logic                  nibCarry;
  logic [W+NIBBLE_W-1:0] resCat;

  nibble_adder_cin u_adder (
    .x  (opA_q[NIBBLE_W-1:0]),
    .y  (opB_q[NIBBLE_W-1:0]),
    .ci (carry_q),
    .s  (nibSum),
    .co (nibCarry)
  );

  // New nibble enters at the top; after NIBBLES shifts the word is in place.
  assign resCat = {nibSum, res_q};
  assign res_d  = resCat[W+NIBBLE_W-1:NIBBLE_W];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      opA_q   <= '0;
      opB_q   <= '0;
      carry_q <= 1'b0;
      res_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            opA_q   <= a;
            opB_q   <= b;
            carry_q <= cin;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          res_q   <= res_d;
          carry_q <= nibCarry;
          opA_q   <= opA_q >> NIBBLE_W;
          opB_q   <= opB_q >> NIBBLE_W;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == CW'(NIBBLES - 1)) begin
            sum_q   <= res_d;
            cout_q  <= nibCarry;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Directed bench for the nibble-serial adder: a 4-nibble and a 1-nibble
// instance share clock and reset; expected values are hand-computed.
module tb_nibble_serial_adder_ctrl;

  logic        clk = 1'b0;
  logic        reset;

  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic [15:0] sum;
  logic        cout;
  logic        busy;
  logic        done;

  logic        start1;
  logic [3:0]  a1;
  logic [3:0]  b1;
  logic        cin1;
  logic [3:0]  sum1;
  logic        cout1;
  logic        busy1;
  logic        done1;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  nibble_serial_adder_ctrl #(.NIBBLES(4)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .sum   (sum),
    .cout  (cout),
    .busy  (busy),
    .done  (done)
  );

  nibble_serial_adder_ctrl #(.NIBBLES(1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .start (start1),
    .a     (a1),
    .b     (b1),
    .cin   (cin1),
    .sum   (sum1),
    .cout  (cout1),
    .busy  (busy1),
    .done  (done1)
  );

  // Advance past the next rising edge; inputs change and outputs are sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic s, input logic [15:0] va,
                               input logic [15:0] vb, input logic c);
    start = s;
    a     = va;
    b     = vb;
    cin   = c;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One full transaction on the 4-nibble instance, checking every cycle.
  task automatic runAdd(input string tag, input logic [15:0] va, input logic [15:0] vb,
                        input logic c, input logic [15:0] prevSum, input logic prevCout,
                        input logic [15:0] expSum, input logic expCout);
    applyStimulus(1'b1, va, vb, c);
    tick();
    applyStimulus(1'b0, 16'h0, 16'h0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      checkOutput({tag, ".busy"}, 32'(busy), 32'd1);
      checkOutput({tag, ".done"}, 32'(done), 32'd0);
      checkOutput({tag, ".hold"}, 32'({cout, sum}), 32'({prevCout, prevSum}));
      tick();
    end
    checkOutput({tag, ".busyLast"}, 32'(busy), 32'd1);
    tick();
    checkOutput({tag, ".donePulse"}, 32'(done), 32'd1);
    checkOutput({tag, ".busyEnd"},   32'(busy), 32'd0);
    checkOutput({tag, ".sum"},       32'(sum),  32'(expSum));
    checkOutput({tag, ".cout"},      32'(cout), 32'(expCout));
    tick();
    checkOutput({tag, ".doneDrop"},  32'(done), 32'd0);
    checkOutput({tag, ".sumHeld"},   32'(sum),  32'(expSum));
  endtask

  initial begin
    reset  = 1'b1;
    applyStimulus(1'b1, 16'hFFFF, 16'hFFFF, 1'b1);
    start1 = 1'b1; a1 = 4'hF; b1 = 4'hF; cin1 = 1'b1;
    tick();
    tick();
    checkOutput("reset.busy", 32'(busy), 32'd0);
    checkOutput("reset.done", 32'(done), 32'd0);
    checkOutput("reset.sum",  32'({cout, sum}), 32'd0);
    checkOutput("reset1.out", 32'({busy1, done1, cout1, sum1}), 32'd0);
    reset = 1'b0;
    applyStimulus(1'b0, 16'h0, 16'h0, 1'b0);
    start1 = 1'b0; a1 = 4'h0; b1 = 4'h0; cin1 = 1'b0;
    tick();

    runAdd("basic",  16'h1234, 16'h1111, 1'b0, 16'h0000, 1'b0, 16'h2345, 1'b0);
    runAdd("chain",  16'hFFFF, 16'h0001, 1'b0, 16'h2345, 1'b0, 16'h0000, 1'b1);
    runAdd("msb",    16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b1);
    runAdd("cinAll", 16'h0000, 16'hFFFF, 1'b1, 16'h0000, 1'b1, 16'h0000, 1'b1);
    runAdd("mid",    16'h00F0, 16'h0010, 1'b0, 16'h0000, 1'b1, 16'h0100, 1'b0);

    // Start raised mid-run must be neither accepted nor queued.
    applyStimulus(1'b1, 16'h0005, 16'h0003, 1'b0);
    tick();
    applyStimulus(1'b0, 16'h0, 16'h0, 1'b0);
    tick();
    applyStimulus(1'b1, 16'hAAAA, 16'h5555, 1'b1);
    tick();
    applyStimulus(1'b0, 16'h0, 16'h0, 1'b0);
    tick();
    tick();
    checkOutput("ignore.done", 32'(done), 32'd1);
    checkOutput("ignore.sum",  32'({cout, sum}), 32'h0_0008);
    for (int k = 0; k < 6; k++) begin
      tick();
      checkOutput("ignore.noSecond", 32'({busy, done}), 32'd0);
    end

    // Reset in the middle of a run clears everything.
    applyStimulus(1'b1, 16'h1234, 16'h4321, 1'b0);
    tick();
    applyStimulus(1'b0, 16'h0, 16'h0, 1'b0);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("midReset.flags", 32'({busy, done}), 32'd0);
    checkOutput("midReset.sum",   32'({cout, sum}), 32'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      checkOutput("midReset.noDone", 32'(done), 32'd0);
    end
    runAdd("afterReset", 16'h0001, 16'h0001, 1'b0, 16'h0000, 1'b0, 16'h0002, 1'b0);

    // Back-to-back: second start lands in the done cycle of the first run.
    applyStimulus(1'b1, 16'h1234, 16'h1111, 1'b0);
    tick();
    applyStimulus(1'b0, 16'h0, 16'h0, 1'b0);
    tick();
    tick();
    tick();
    tick();
    checkOutput("b2b.firstDone", 32'(done), 32'd1);
    checkOutput("b2b.firstSum",  32'({cout, sum}), 32'h0_2345);
    applyStimulus(1'b1, 16'h0F0F, 16'h0101, 1'b1);
    tick();
    applyStimulus(1'b0, 16'h0, 16'h0, 1'b0);
    checkOutput("b2b.accepted", 32'({busy, done}), 32'b10);
    for (int k = 0; k < 3; k++) begin
      checkOutput("b2b.holdFirst", 32'({cout, sum}), 32'h0_2345);
      tick();
    end
    tick();
    checkOutput("b2b.secondDone", 32'(done), 32'd1);
    checkOutput("b2b.secondSum",  32'({cout, sum}), 32'h0_1011);

    // Single-nibble instance completes one cycle after the accepted start.
    start1 = 1'b1; a1 = 4'hF; b1 = 4'h1; cin1 = 1'b0;
    tick();
    start1 = 1'b0; a1 = 4'h0; b1 = 4'h0;
    checkOutput("n1.busy", 32'({busy1, done1}), 32'b10);
    tick();
    checkOutput("n1.done", 32'({busy1, done1}), 32'b01);
    checkOutput("n1.sum",  32'({cout1, sum1}), 32'h10);
    tick();
    checkOutput("n1.doneDrop", 32'(done1), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
